spi_slave_shift_register: RTL

Responder-side SPI character engine: the opposite end of the link from the master shift register. It samples an external SPI bus (sclk, ss_n, mosi) into the wishbone clock domain and shifts one character of 1..32 bits per slave-select assertion. It drives miso from a host-loaded transmit buffer and presents the received character in parallel on `p_out`. Edge polarity, bit order and character length share the master's control encoding, so a master and slave configured identically interoperate.

---
 rtl/spi_slave_shift_register.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_shift_register.sv
// SPI responder character engine: samples sclk/ss_n/mosi into wb_clk_in and shifts one 1..32-bit character per select.
// Optional build macro SPI_SLAVE_MISO_OE_EN adds miso_oe and forces miso low while not selected.
module spi_slave_shift_register #(
    parameter int SPI_MAX_CHAR      = 32,
    parameter int SPI_CHAR_LEN_BITS = 5
) (
    input  logic                         wb_clk_in,
    input  logic                         wb_rst,
    input  logic                         rx_negedge,
    input  logic                         tx_negedge,
    input  logic                         lsb,
    input  logic [SPI_CHAR_LEN_BITS-1:0] len,
    input  logic [SPI_MAX_CHAR-1:0]      tx_data,
    input  logic                         tx_load,
    input  logic                         sclk_in,
    input  logic                         ss_n_in,
    input  logic                         mosi_in,
    output logic                         miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                         miso_oe,
`endif
    output logic [SPI_MAX_CHAR-1:0]      p_out,
    output logic                         rx_valid,
    output logic                         last,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    localparam int LW = SPI_CHAR_LEN_BITS;

    state_t                  state;
    logic [2:0]              sclk_sync;
    logic [2:0]              ss_sync;
    logic [1:0]              mosi_sync;
    logic [SPI_MAX_CHAR-1:0] tx_buf;
    logic [SPI_MAX_CHAR-1:0] rx_shift;
    logic [LW-1:0]           last_idx;
    logic [LW-1:0]           bit_cnt;
    logic                    lsb_l;
    logic                    rx_neg_l;
    logic                    tx_neg_l;
    logic                    seen_rx;
    logic                    pend;
    logic                    miso_q;

    // Bits [0] and [1] form the synchronizer; [2] is the history flop for edge detection.
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk_in};
            ss_sync   <= {ss_sync[1:0], ss_n_in};
            mosi_sync <= {mosi_sync[0], mosi_in};
        end
    end

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, rx_edge, tx_edge, mosi_s;
    logic [LW-1:0]           cur_idx;
    logic [LW-1:0]           first_idx;
    logic [SPI_MAX_CHAR-1:0] load_word;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign mosi_s    = mosi_sync[1];
    assign rx_edge   = rx_neg_l ? sclk_fall : sclk_rise;
    assign tx_edge   = tx_neg_l ? sclk_fall : sclk_rise;

    // len - 1 wraps 0 to the top index, so len = 0 naturally means a full-width character.
    assign cur_idx   = lsb_l ? bit_cnt : (last_idx - bit_cnt);
    assign first_idx = lsb ? '0 : (len - LW'(1));
    assign load_word = tx_load ? tx_data : tx_buf;

    // rx_valid is a one-cycle pulse qualifying p_out; there is no ready, the host must take it that cycle.
    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state    <= IDLE;
            tx_buf   <= '0;
            rx_shift <= '0;
            last_idx <= '0;
            bit_cnt  <= '0;
            lsb_l    <= 1'b0;
            rx_neg_l <= 1'b0;
            tx_neg_l <= 1'b0;
            seen_rx  <= 1'b0;
            pend     <= 1'b0;
            miso_q   <= 1'b0;
            p_out    <= '0;
            rx_valid <= 1'b0;
            last     <= 1'b0;
        end else begin
            last     <= 1'b0;
            pend     <= 1'b0;
            rx_valid <= pend;
            if (pend) p_out <= rx_shift;
            case (state)
                IDLE: begin
                    if (tx_load) tx_buf <= tx_data;
                    if (ss_fall) begin
                        state    <= ACTIVE;
                        last_idx <= len - LW'(1);
                        lsb_l    <= lsb;
                        rx_neg_l <= rx_negedge;
                        tx_neg_l <= tx_negedge;
                        bit_cnt  <= '0;
                        seen_rx  <= 1'b0;
                        rx_shift <= '0;
                        miso_q   <= load_word[first_idx];
                    end
                end
                ACTIVE: begin
                    if (rx_edge && (bit_cnt == last_idx)) begin
                        // A completing edge wins over a simultaneous deselect.
                        rx_shift[cur_idx] <= mosi_s;
                        bit_cnt           <= bit_cnt + LW'(1);
                        last              <= 1'b1;
                        pend              <= 1'b1;
                        state             <= ss_rise ? IDLE : DONE;
                    end else if (ss_rise) begin
                        state <= IDLE;
                    end else begin
                        if (rx_edge) begin
                            rx_shift[cur_idx] <= mosi_s;
                            bit_cnt           <= bit_cnt + LW'(1);
                            seen_rx           <= 1'b1;
                        end
                        if (tx_edge && seen_rx) miso_q <= tx_buf[cur_idx];
                    end
                end
                DONE: begin
                    if (ss_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso_oe = (state != IDLE);
    assign miso    = miso_oe & miso_q;
`else
    assign miso    = miso_q;
`endif

endmodule
